lcd_timing: RTL and testbench

LCD_TIMING -- requirements
Module: lcd_timing

---
 rtl/lcd_timing_if.sv | 23 ++
 rtl/lcd_timing.sv | 117 +++++++++++
 tb/tb_lcd_timing.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_if.sv
// Tile-layer and panel signals of the LCD timing generator.
// master: the timing generator; slave: the tile-layer stage and the panel.
interface lcd_timing_if;
    logic [23:0] i_color;
    logic        o_lcd_clk;
    logic [8:0]  o_x;
    logic [8:0]  o_y;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;
    logic [23:0] o_rgb;
    logic        o_frame_start;

    modport master (
        input  i_color,
        output o_lcd_clk, o_x, o_y, o_hsync, o_vsync, o_de, o_rgb, o_frame_start
    );

    modport slave (
        output i_color,
        input  o_lcd_clk, o_x, o_y, o_hsync, o_vsync, o_de, o_rgb, o_frame_start
    );
endinterface

// File: rtl/lcd_timing.sv
// Parallel-RGB LCD timing generator: pixel-clock divider, h/v raster counters and a
// registered panel stage that lags the presented coordinate by one pixel.
module lcd_timing #(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    lcd_timing_if.master  bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    // Sync windows as [begin, end) in counter units.
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             lcd_clk_q, lcd_clk_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             frame_start_q, frame_start_d;

    logic tick;
    logic h_wrap;
    logic v_wrap;
    logic active;

    always_comb begin
        tick   = (div_q == DIV_LAST);
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        // Pre-advance position: drives o_x/o_y now and becomes de_nxt at the tick.
        active = (h_q < H_ACT) && (v_q < V_ACT);

        div_d         = tick ? '0 : div_q + 1'b1;
        h_d           = h_q;
        v_d           = v_q;
        lcd_clk_d     = lcd_clk_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;

        if (tick) begin
            h_d = h_wrap ? '0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 10'd1;
            end
            lcd_clk_d     = 1'b1;
            de_d          = active;
            rgb_d         = active ? bus.i_color : 24'h000000;
            hsync_d       = !((h_q >= HS_BEGIN) && (h_q < HS_END));
            vsync_d       = !((v_q >= VS_BEGIN) && (v_q < VS_END));
            frame_start_d = h_wrap && v_wrap;
        end else if (div_q == DIV_HALF) begin
            lcd_clk_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q         <= '0;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            lcd_clk_q     <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            rgb_q         <= 24'h000000;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            lcd_clk_q     <= lcd_clk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.o_lcd_clk     = lcd_clk_q;
    assign bus.o_x           = active ? h_q[8:0] : 9'd0;
    assign bus.o_y           = active ? v_q[8:0] : 9'd0;
    assign bus.o_hsync       = hsync_q;
    assign bus.o_vsync       = vsync_q;
    assign bus.o_de          = de_q;
    assign bus.o_rgb         = rgb_q;
    assign bus.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing.sv
// Bench for lcd_timing on a reduced raster (28x10, divide-by-8) so whole frames fit in a short run.
module tb_lcd_timing;

    localparam int CD  = 8;
    localparam int HA  = 20;
    localparam int HFP = 2;
    localparam int HS  = 4;
    localparam int HBP = 2;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    typedef struct packed {
        logic        lcd_clk;
        logic        fs;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } outs_t;

    typedef struct {
        int   n;
        logic lcd_clk;
        logic fs;
        int   x;
        int   y;
        logic de;
        logic hs;
        logic vs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_timing_if bus();

    lcd_timing #(
        .CLK_DIV (CD),
        .H_ACTIVE(HA),
        .H_FP    (HFP),
        .H_SYNC  (HS),
        .H_BP    (HBP),
        .V_ACTIVE(VA),
        .V_FP    (VFP),
        .V_SYNC  (VS),
        .V_BP    (VBP)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n;            // edges since reset release (0 = in/just out of reset)
    int vectors;
    int miscompares;
    logic [23:0] colors [0:4095];   // colour presented during the period after tick k

    // Reference: everything follows from the count of edges since release.
    function automatic outs_t model_at(int cyc);
        outs_t e;
        int t, pix, h, v, pp, ph, pv;
        e = '{lcd_clk: 1'b0, fs: 1'b0, x: 9'd0, y: 9'd0, hs: 1'b1, vs: 1'b1, de: 1'b0,
              rgb: 24'd0};
        t = cyc / CD;
        if (t >= 1) begin
            pix = (t - 1) % FT;
            h   = pix % HT;
            v   = pix / HT;
            e.lcd_clk = (cyc % CD) < CD / 2;
            e.fs      = (cyc % CD == 0) && (pix == 0);
            if (h < HA && v < VA) begin
                e.x = 9'(h);
                e.y = 9'(v);
            end
            pp   = (t - 2 + FT) % FT;
            ph   = pp % HT;
            pv   = pp / HT;
            e.de = (ph < HA) && (pv < VA);
            e.hs = !((ph >= HA + HFP) && (ph < HA + HFP + HS));
            e.vs = !((pv >= VA + VFP) && (pv < VA + VFP + VS));
            e.rgb = e.de ? colors[(t - 1) % 4096] : 24'd0;
        end
        return e;
    endfunction

    task automatic step();
        int t, pix, h, v;
        logic [23:0] col;
        @(posedge clk);
        #1;
        if (rst) n = 0;
        else n++;
        if (n >= CD && n % CD == 0) begin
            t   = n / CD;
            pix = (t - 1) % FT;
            h   = pix % HT;
            v   = pix / HT;
            col = {6'($urandom), 18'd0};
            if (h < HA && v < VA) col[17:0] = {9'(v), 9'(h)};
            colors[t % 4096] = col;
            bus.i_color = col;
        end
    endtask

    task automatic check_model();
        outs_t e, a;
        e = model_at(n);
        a = '{lcd_clk: bus.o_lcd_clk, fs: bus.o_frame_start, x: bus.o_x, y: bus.o_y,
              hs: bus.o_hsync, vs: bus.o_vsync, de: bus.o_de, rgb: bus.o_rgb};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL model n=%0d got {clk fs x y hs vs de rgb}=%b %b %0d %0d %b %b %b %h want %b %b %0d %0d %b %b %b %h",
                     n, a.lcd_clk, a.fs, a.x, a.y, a.hs, a.vs, a.de, a.rgb,
                     e.lcd_clk, e.fs, e.x, e.y, e.hs, e.vs, e.de, e.rgb);
        end
    endtask

    task automatic chk(string name, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            step();
            check_model();
        end
        rst = 1'b0;
    endtask

    initial begin
        vec_t tab[$];
        int gap, run, first_run, de_cnt, vs_cnt;
        bit seen;

        n = 0;
        vectors = 0;
        miscompares = 0;
        bus.i_color = 24'd0;
        for (int i = 0; i < 4096; i++) colors[i] = 24'd0;

        //             n     clk   fs    x  y  de    hs    vs
        tab.push_back('{0,    1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1});
        tab.push_back('{7,    1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1});
        tab.push_back('{8,    1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1});
        tab.push_back('{11,   1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1});
        tab.push_back('{12,   1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1});
        tab.push_back('{16,   1'b1, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1});
        tab.push_back('{168,  1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1});
        tab.push_back('{176,  1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1});
        tab.push_back('{192,  1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1});
        tab.push_back('{216,  1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1});
        tab.push_back('{224,  1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1});
        tab.push_back('{232,  1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1});
        tab.push_back('{240,  1'b1, 1'b0, 1, 1, 1'b1, 1'b1, 1'b1});
        tab.push_back('{1576, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1});
        tab.push_back('{1584, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{2244, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1});
        tab.push_back('{2248, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1});

        // Reset release and first frame against the hand-computed table.
        do_reset(3);
        foreach (tab[i]) begin
            while (n < tab[i].n) begin
                step();
                check_model();
            end
            vectors++;
            if (bus.o_lcd_clk !== tab[i].lcd_clk || bus.o_frame_start !== tab[i].fs ||
                int'(bus.o_x) != tab[i].x || int'(bus.o_y) != tab[i].y ||
                bus.o_de !== tab[i].de || bus.o_hsync !== tab[i].hs ||
                bus.o_vsync !== tab[i].vs) begin
                miscompares++;
                $display("FAIL table n=%0d got clk=%b fs=%b x=%0d y=%0d de=%b hs=%b vs=%b want clk=%b fs=%b x=%0d y=%0d de=%b hs=%b vs=%b",
                         n, bus.o_lcd_clk, bus.o_frame_start, bus.o_x, bus.o_y, bus.o_de,
                         bus.o_hsync, bus.o_vsync, tab[i].lcd_clk, tab[i].fs, tab[i].x,
                         tab[i].y, tab[i].de, tab[i].hs, tab[i].vs);
            end
        end

        // One full frame: pulse spacing, hsync run, vsync and de tick counts.
        gap = 0; run = 0; first_run = -1; de_cnt = 0; vs_cnt = 0; seen = 1'b0;
        for (int c = 0; c < FT * CD + 50 && !seen; c++) begin
            step();
            check_model();
            gap++;
            if (n % CD == 0) begin
                if (!bus.o_hsync) run++;
                else begin
                    if (run > 0 && first_run < 0) first_run = run;
                    run = 0;
                end
                if (bus.o_de) de_cnt++;
                if (!bus.o_vsync) vs_cnt++;
            end
            if (bus.o_frame_start) seen = 1'b1;
        end
        chk("frame_gap", seen ? gap : -1, FT * CD);
        chk("hsync_run", first_run, HS);
        chk("de_ticks", de_cnt, HA * VA);
        chk("vsync_ticks", vs_cnt, VS * HT);

        // Mid-frame reset at h=10, v=3.
        seen = 1'b0;
        for (int c = 0; c < FT * CD + 50 && !seen; c++) begin
            step();
            check_model();
            if (n % CD == 3 && (n / CD - 1) % FT == 3 * HT + 10) seen = 1'b1;
        end
        chk("midframe_reached", int'(seen), 1);
        chk("midframe_x", int'(bus.o_x), 10);
        chk("midframe_y", int'(bus.o_y), 3);
        do_reset(1);
        chk("rst_lcd_clk", int'(bus.o_lcd_clk), 0);
        chk("rst_hsync", int'(bus.o_hsync), 1);
        repeat (CD - 1) begin
            step();
            check_model();
        end
        chk("pre_tick_clk", int'(bus.o_lcd_clk), 0);
        step();
        check_model();
        chk("rel_lcd_clk", int'(bus.o_lcd_clk), 1);
        chk("rel_frame_start", int'(bus.o_frame_start), 1);
        step();
        chk("frame_start_width", int'(bus.o_frame_start), 0);

        // Random run lengths with random reset pulses, checked every cycle.
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(100, 2500)) begin
                step();
                check_model();
            end
            do_reset(int'($urandom_range(1, 3)));
        end
        repeat (300) begin
            step();
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
